uart_cmd_wrapper: RTL and testbench
===================================

Name: uart_cmd_wrapper

Overview:
Host-side serial front end of the logic analyzer. It deserialises 8N1 UART bytes from the RX pin and assembles pairs (high byte first) into 16-bit commands for the command/config stage via cmd/cmd_rdy/clr_cmd_rdy. It also serialises 8-bit responses from that stage onto TX via send_resp/resp_sent. Bit period comes from the run-time baud register {baud_cntH, baud_cntL}, which the config stage produces.

Parameters:
BAUD_W, 16, width of baud_cnt (clocks per bit)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
RX  in  1  async serial input, idle high
TX  out  1  serial output, idle high
baud_cnt  in  BAUD_W  clocks per bit, = {baud_cntH, baud_cntL}; reset value upstream 0x06C8
cmd  out  16  last complete command {byte0, byte1}
cmd_rdy  out  1  command valid; level, held until cleared
clr_cmd_rdy  in  1  consumer acknowledge; clears cmd_rdy
resp  in  8  response byte to transmit
send_resp  in  1  one-cycle request to transmit resp
resp_sent  out  1  one-cycle pulse when the response stop bit completes
tx_busy  out  1  transmitter active

Behaviour:
- Reset: TX=1, cmd=0x0000, cmd_rdy=0, resp_sent=0, tx_busy=0, RX synchroniser flops=1, both FSMs idle, byte phase=HIGH.
- RX sync: two flops, preset high. Start = synchronised RX 1->0.
- baud_cnt is latched at each frame start (RX and TX separately). Changes mid-frame affect only the next frame.
- RX FSM, states IDLE, START, DATA, STOP:
  - IDLE -> START on start edge; load counter with baud/2 (baud>>1).
  - START: at expiry, if RX=1 it is a false start -> IDLE; else go to DATA, counter=baud.
  - DATA: sample at each expiry, shift in LSB first; after 8 samples -> STOP.
  - STOP: sample at expiry. 1 means byte valid (internal pulse next cycle). 0 means framing error: byte discarded, byte phase unchanged. -> IDLE.
- Assembly FSM, phases HIGH and LOW:
  - HIGH: a valid byte goes to the hold register; -> LOW.
  - LOW: a valid byte makes cmd <= {hold, byte}, cmd_rdy <= 1; -> HIGH.
  - cmd updates only atomically at pair completion and is stable between completions.
- cmd_rdy:
  - Cleared on clr_cmd_rdy.
  - Completion in the same cycle as clr_cmd_rdy: set wins, cmd takes the new value.
  - A new pair completing while cmd_rdy=1 overwrites cmd; cmd_rdy stays 1 (no overrun flag).
- TX FSM, states IDLE, XMIT:
  - send_resp in IDLE loads {1, resp, 0} and asserts tx_busy next cycle.
  - Each bit is held baud cycles: start, D0..D7, stop.
  - After the stop bit: resp_sent pulses 1 cycle, tx_busy drops the same cycle, TX=1.
  - send_resp while tx_busy is ignored.
- Latencies:
  - cmd_rdy rises 2 cycles after the second byte's stop sample.
  - First TX start bit appears 1 cycle after send_resp.
  - resp_sent occurs 10*baud+1 cycles after send_resp.
- Reset mid-frame aborts both FSMs; the partial byte and the hold register are discarded.
- baud_cnt < 4 is unsupported (undefined).

Decomposition:
- Package uart_pkg: rx_state_t, tx_state_t enums; localparams FRAME_BITS=10, DATA_BITS=8.
- Sub-module uart_tx (shift register plus baud counter). RX and assembly logic are inline in the wrapper.

Test Plan:
- Reset, then idle: TX=1, cmd=0, cmd_rdy=0 held for 1000 cycles with RX=1.
- baud=16; send bytes 0x41 then 0x23 -> cmd=0x4123, cmd_rdy=1 two cycles after stop sample; pulse clr_cmd_rdy -> cmd_rdy=0 next cycle, cmd held.
- baud=16; 6-cycle low glitch on RX, then byte 0x81, 0x05 -> glitch ignored, cmd=0x8105. Then a byte with stop=0 followed by 0xC0, 0x00 -> framing-error byte dropped, cmd=0xC000.
- send_resp with resp=0xA5, baud=16 -> TX start bit, LSB-first bit sequence 1,0,1,0,0,1,0,1, then stop; each bit 16 cycles. resp_sent at cycle 161; second send_resp at cycle 50 ignored.
- Baud change from 16 to 32 mid-RX-frame -> current byte decoded at 16, next byte at 32, both correct.
- Second pair completes while cmd_rdy=1 and clr_cmd_rdy arrives in the same cycle -> cmd=new value, cmd_rdy=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and state encodings for the UART command front end.
package uart_pkg;

  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned DATA_BITS  = 8;

  typedef logic [1:0] rx_state_t;
  localparam rx_state_t RX_IDLE  = 2'd0;
  localparam rx_state_t RX_START = 2'd1;
  localparam rx_state_t RX_DATA  = 2'd2;
  localparam rx_state_t RX_STOP  = 2'd3;

  typedef logic tx_state_t;
  localparam tx_state_t TX_IDLE = 1'b0;
  localparam tx_state_t TX_XMIT = 1'b1;

endpackage

// File: rtl/uart_tx.sv
// 8N1 transmitter: frame shift register plus per-frame latched baud counter.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BAUD_W-1:0]    baud_cnt,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 start,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned BIT_W = 4;

  tx_state_t            state, state_d;
  logic [BAUD_W-1:0]    cnt, cnt_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [BIT_W-1:0]     bits, bits_d;
  logic [DATA_BITS:0]   shift, shift_d;
  logic                 tx_d, busy_d, done_d;

  // State and datapath registers; line idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= TX_IDLE;
      cnt    <= '0;
      baud_q <= '0;
      bits   <= '0;
      shift  <= '1;
      tx     <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      baud_q <= baud_d;
      bits   <= bits_d;
      shift  <= shift_d;
      tx     <= tx_d;
      busy   <= busy_d;
      done   <= done_d;
    end
  end

  // Next state: each frame bit is held baud_q cycles; stop bit ends with a done pulse.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    baud_d  = baud_q;
    bits_d  = bits;
    shift_d = shift;
    tx_d    = tx;
    busy_d  = busy;
    done_d  = 1'b0;
    case (state)
      TX_IDLE: begin
        if (start) begin
          state_d = TX_XMIT;
          baud_d  = baud_cnt;
          cnt_d   = baud_cnt;
          shift_d = {1'b1, data};
          bits_d  = '0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      TX_XMIT: begin
        if (cnt == BAUD_W'(1)) begin
          if (bits == BIT_W'(FRAME_BITS - 1)) begin
            state_d = TX_IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            tx_d    = shift[0];
            shift_d = {1'b1, shift[DATA_BITS:1]};
            bits_d  = bits + BIT_W'(1);
            cnt_d   = baud_q;
          end
        end else begin
          cnt_d = cnt - BAUD_W'(1);
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_cmd_wrapper.sv
// Host serial front end: RX bytes paired into 16-bit commands, responses sent on TX.
module uart_cmd_wrapper
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RX,
  output logic              TX,
  input  logic [BAUD_W-1:0] baud_cnt,
  output logic [15:0]       cmd,
  output logic              cmd_rdy,
  input  logic              clr_cmd_rdy,
  input  logic [7:0]        resp,
  input  logic              send_resp,
  output logic              resp_sent,
  output logic              tx_busy
);

  localparam int unsigned RXB_W = 3;
  localparam logic PH_HIGH = 1'b0;
  localparam logic PH_LOW  = 1'b1;

  logic                 rx_meta, rx_sync, rx_prev;
  rx_state_t            rx_state, rx_state_d;
  logic [BAUD_W-1:0]    rx_cnt, rx_cnt_d, rx_baud, rx_baud_d;
  logic [RXB_W-1:0]     rx_bits, rx_bits_d;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_d;
  logic                 rx_vld, rx_vld_d;
  logic                 rx_expire;
  logic                 phase, phase_d;
  logic [7:0]           hold, hold_d;
  logic [15:0]          cmd_d;
  logic                 cmd_rdy_d;

  // Two-flop synchroniser plus edge history, preset to idle-high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_expire = (rx_cnt == BAUD_W'(1));

  // RX and assembly state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_baud  <= '0;
      rx_bits  <= '0;
      rx_shift <= '0;
      rx_vld   <= 1'b0;
      phase    <= PH_HIGH;
      hold     <= '0;
      cmd      <= '0;
      cmd_rdy  <= 1'b0;
    end else begin
      rx_state <= rx_state_d;
      rx_cnt   <= rx_cnt_d;
      rx_baud  <= rx_baud_d;
      rx_bits  <= rx_bits_d;
      rx_shift <= rx_shift_d;
      rx_vld   <= rx_vld_d;
      phase    <= phase_d;
      hold     <= hold_d;
      cmd      <= cmd_d;
      cmd_rdy  <= cmd_rdy_d;
    end
  end

  // RX next state: half-bit wait to mid start bit, then full-bit sampling LSB first.
  always_comb begin
    rx_state_d = rx_state;
    rx_cnt_d   = rx_cnt;
    rx_baud_d  = rx_baud;
    rx_bits_d  = rx_bits;
    rx_shift_d = rx_shift;
    rx_vld_d   = 1'b0;
    if (rx_state != RX_IDLE && !rx_expire) rx_cnt_d = rx_cnt - BAUD_W'(1);
    case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx_sync) begin
          rx_state_d = RX_START;
          rx_baud_d  = baud_cnt;
          rx_cnt_d   = baud_cnt >> 1;
        end
      end
      RX_START: begin
        if (rx_expire) begin
          if (rx_sync) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
            rx_cnt_d   = rx_baud;
            rx_bits_d  = '0;
          end
        end
      end
      RX_DATA: begin
        if (rx_expire) begin
          rx_shift_d = {rx_sync, rx_shift[DATA_BITS-1:1]};
          rx_cnt_d   = rx_baud;
          if (rx_bits == RXB_W'(DATA_BITS - 1)) rx_state_d = RX_STOP;
          else rx_bits_d = rx_bits + RXB_W'(1);
        end
      end
      RX_STOP: begin
        if (rx_expire) begin
          rx_state_d = RX_IDLE;
          rx_vld_d   = rx_sync;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Pair assembly: high byte held, low byte commits cmd atomically; set beats clear.
  always_comb begin
    phase_d   = phase;
    hold_d    = hold;
    cmd_d     = cmd;
    cmd_rdy_d = cmd_rdy;
    if (clr_cmd_rdy) cmd_rdy_d = 1'b0;
    if (rx_vld) begin
      if (phase == PH_HIGH) begin
        hold_d  = rx_shift;
        phase_d = PH_LOW;
      end else begin
        cmd_d     = {hold, rx_shift};
        cmd_rdy_d = 1'b1;
        phase_d   = PH_HIGH;
      end
    end
  end

  uart_tx #(.BAUD_W(BAUD_W)) u_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .baud_cnt (baud_cnt),
    .data     (resp),
    .start    (send_resp),
    .tx       (TX),
    .busy     (tx_busy),
    .done     (resp_sent)
  );

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Directed bench for uart_cmd_wrapper: command assembly, framing, TX timing.
module tb_uart_cmd_wrapper;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        TX;
  logic [15:0] baud_cnt = 16'd16;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        send_resp = 1'b0;
  logic        resp_sent;
  logic        tx_busy;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   rise_cyc = -1;
  logic rdy_q = 1'b0;

  uart_cmd_wrapper #(.BAUD_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX          (RX),
    .TX          (TX),
    .baud_cnt    (baud_cnt),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp        (resp),
    .send_resp   (send_resp),
    .resp_sent   (resp_sent),
    .tx_busy     (tx_busy)
  );

  always #5 clk = ~clk;

  // Cycle counter and cmd_rdy rising-edge timestamp.
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    rdy_q <= cmd_rdy;
    if (cmd_rdy && !rdy_q) rise_cyc <= cyc;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one 8N1 frame with b clocks per bit, starting on a falling edge.
  task automatic rx_frame(input logic [7:0] d, input logic stop, input int b);
    @(negedge clk);
    start_cyc = cyc;
    RX = 1'b0;
    repeat (b) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = d[i];
      repeat (b) @(negedge clk);
    end
    RX = stop;
    repeat (b) @(negedge clk);
    RX = 1'b1;
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
  endtask

  initial begin
    int        bad_idle, bad_tx, bad_busy, sent_at, exp_rise;
    logic [9:0] frame;

    // Reset and idle behaviour
    ticks(3);
    rst_n = 1'b1;
    check("rst_tx", 32'(TX), 32'd1);
    check("rst_cmd", 32'(cmd), 32'h0);
    check("rst_rdy", 32'(cmd_rdy), 32'd0);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_sent", 32'(resp_sent), 32'd0);
    bad_idle = 0;
    repeat (1000) begin
      @(negedge clk);
      if (TX !== 1'b1 || cmd !== 16'h0 || cmd_rdy !== 1'b0 || tx_busy !== 1'b0) bad_idle++;
    end
    check("idle_1000", 32'(bad_idle), 32'd0);

    // Basic pair at baud 16, latency, then acknowledge
    rx_frame(8'h41, 1'b1, 16);
    check("pair1_half_rdy", 32'(cmd_rdy), 32'd0);
    rx_frame(8'h23, 1'b1, 16);
    exp_rise = start_cyc + 9 * 16 + 8 + 4;
    check("pair1_cmd", 32'(cmd), 32'h4123);
    check("pair1_rdy", 32'(cmd_rdy), 32'd1);
    check("pair1_latency", 32'(rise_cyc), 32'(exp_rise));
    pulse_clr();
    check("clr_rdy", 32'(cmd_rdy), 32'd0);
    check("clr_cmd_held", 32'(cmd), 32'h4123);

    // Glitch rejection, then framing-error byte dropped
    RX = 1'b0;
    ticks(6);
    RX = 1'b1;
    ticks(200);
    check("glitch_rdy", 32'(cmd_rdy), 32'd0);
    check("glitch_cmd", 32'(cmd), 32'h4123);
    rx_frame(8'h81, 1'b1, 16);
    rx_frame(8'h05, 1'b1, 16);
    check("glitch_pair_cmd", 32'(cmd), 32'h8105);
    check("glitch_pair_rdy", 32'(cmd_rdy), 32'd1);
    pulse_clr();
    rx_frame(8'h77, 1'b0, 16);
    ticks(32);
    rx_frame(8'hC0, 1'b1, 16);
    check("ferr_half_rdy", 32'(cmd_rdy), 32'd0);
    rx_frame(8'h00, 1'b1, 16);
    check("ferr_cmd", 32'(cmd), 32'hC000);
    check("ferr_rdy", 32'(cmd_rdy), 32'd1);

    // Response transmit 0xA5 at baud 16, with an ignored request mid-frame
    resp = 8'hA5;
    frame = {1'b1, 8'hA5, 1'b0};
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    bad_tx = 0;
    bad_busy = 0;
    sent_at = 0;
    for (int k = 1; k <= 175; k++) begin
      if (k <= 160) begin
        if (TX !== frame[(k-1)/16]) bad_tx++;
        if (tx_busy !== 1'b1) bad_busy++;
        if (((k - 1) % 16) == 8)
          check($sformatf("tx_bit%0d", (k-1)/16), 32'(TX), 32'(frame[(k-1)/16]));
      end
      if (resp_sent === 1'b1 && sent_at == 0) sent_at = k;
      if (k == 161) begin
        check("tx_done_busy", 32'(tx_busy), 32'd0);
        check("tx_done_line", 32'(TX), 32'd1);
      end
      if (k == 50) begin
        resp = 8'hFF;
        send_resp = 1'b1;
      end
      if (k == 51) send_resp = 1'b0;
      @(negedge clk);
    end
    check("tx_all_bits", 32'(bad_tx), 32'd0);
    check("tx_busy_held", 32'(bad_busy), 32'd0);
    check("resp_sent_at", 32'(sent_at), 32'd161);

    // Reset with a held high byte and an active transmit discards both
    rx_frame(8'h99, 1'b1, 16);
    resp = 8'h3C;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    ticks(30);
    check("prerst_busy", 32'(tx_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_tx", 32'(TX), 32'd1);
    check("midrst_busy", 32'(tx_busy), 32'd0);
    check("midrst_cmd", 32'(cmd), 32'h0);
    check("midrst_rdy", 32'(cmd_rdy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rx_frame(8'h12, 1'b1, 16);
    rx_frame(8'h34, 1'b1, 16);
    check("postrst_cmd", 32'(cmd), 32'h1234);
    pulse_clr();

    // Baud change mid-frame applies only to the next frame
    fork
      rx_frame(8'h3C, 1'b1, 16);
      begin
        ticks(70);
        baud_cnt = 16'd32;
      end
    join
    rx_frame(8'hA7, 1'b1, 32);
    exp_rise = start_cyc + 9 * 32 + 16 + 4;
    check("baud_cmd", 32'(cmd), 32'h3CA7);
    check("baud_rdy", 32'(cmd_rdy), 32'd1);
    check("baud_latency", 32'(rise_cyc), 32'(exp_rise));

    // Overwrite while cmd_rdy set, with clear landing on the completion cycle
    rx_frame(8'h5A, 1'b1, 32);
    check("ovr_half_cmd", 32'(cmd), 32'h3CA7);
    check("ovr_half_rdy", 32'(cmd_rdy), 32'd1);
    fork
      rx_frame(8'h0F, 1'b1, 32);
      begin
        @(negedge clk);
        ticks(9 * 32 + 16 + 3);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        check("ovr_clr_cmd", 32'(cmd), 32'h5A0F);
        check("ovr_clr_rdy", 32'(cmd_rdy), 32'd1);
      end
    join
    check("ovr_final_rdy", 32'(cmd_rdy), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
